// File: rtl/mouse_master_sm.sv
// PS/2 mouse sequencer: runs the power-up handshake (reset, self-test, ID,
// enable streaming), then assembles 3-byte movement packets and publishes
// them with a one-cycle interrupt.
module mouse_master_sm #(
  parameter int unsigned T_INIT_WAIT    = 5000000,
  parameter int unsigned T_RESP_TIMEOUT = 2000000,
  parameter int unsigned T_PKT_TIMEOUT  = 200000,
  parameter int unsigned CTR_WIDTH      = 24
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       INIT_DONE,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT
);

  localparam logic [CTR_WIDTH-1:0] INIT_LAST = CTR_WIDTH'(T_INIT_WAIT - 1);
  localparam logic [CTR_WIDTH-1:0] RESP_LAST = CTR_WIDTH'(T_RESP_TIMEOUT - 1);
  localparam logic [CTR_WIDTH-1:0] PKT_LAST  = CTR_WIDTH'(T_PKT_TIMEOUT - 1);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT    = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [3:0] {
    INIT_WAIT     = 4'd0,
    SEND_RST      = 4'd1,
    WAIT_RST_SENT = 4'd2,
    WAIT_ACK      = 4'd3,
    WAIT_BAT      = 4'd4,
    WAIT_ID       = 4'd5,
    SEND_EN       = 4'd6,
    WAIT_EN_SENT  = 4'd7,
    WAIT_EN_ACK   = 4'd8,
    RX_B0         = 4'd9,
    RX_B1         = 4'd10,
    RX_B2         = 4'd11,
    PUBLISH       = 4'd12
  } state_t;

  state_t                 state;
  logic [CTR_WIDTH-1:0]   ctr;
  logic [7:0]             sh_status;
  logic [7:0]             sh_dx;
  logic [7:0]             sh_dy;
  logic                   good_byte;
  logic                   bad_byte;
  logic [7:0]             exp_byte;

  // Classify the incoming byte and select the response each expect-state wants
  always_comb begin
    good_byte = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
    bad_byte  = BYTE_READY && (BYTE_ERROR_CODE != 2'b00);
    exp_byte  = RSP_ACK;
    case (state)
      WAIT_BAT: exp_byte = RSP_BAT;
      WAIT_ID:  exp_byte = RSP_ID;
      default:  exp_byte = RSP_ACK;
    endcase
  end

  // Sequencer: state, shared counter, shadow packet and all registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= INIT_WAIT;
      ctr            <= '0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= 8'h00;
      READ_ENABLE    <= 1'b0;
      INIT_DONE      <= 1'b0;
      MOUSE_STATUS   <= 8'h00;
      MOUSE_DX       <= 8'h00;
      MOUSE_DY       <= 8'h00;
      SEND_INTERRUPT <= 1'b0;
      sh_status      <= 8'h00;
      sh_dx          <= 8'h00;
      sh_dy          <= 8'h00;
    end else begin
      SEND_BYTE      <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
      ctr            <= ctr + CTR_WIDTH'(1);
      case (state)
        INIT_WAIT: begin
          if (ctr == INIT_LAST) begin
            state <= SEND_RST;
            ctr   <= '0;
          end
        end
        SEND_RST: begin
          SEND_BYTE    <= 1'b1;
          BYTE_TO_SEND <= CMD_RESET;
          state        <= WAIT_RST_SENT;
          ctr          <= '0;
        end
        SEND_EN: begin
          SEND_BYTE    <= 1'b1;
          BYTE_TO_SEND <= CMD_ENABLE;
          state        <= WAIT_EN_SENT;
          ctr          <= '0;
        end
        WAIT_RST_SENT, WAIT_EN_SENT: begin
          if (BYTE_SENT) begin
            state       <= (state == WAIT_RST_SENT) ? WAIT_ACK : WAIT_EN_ACK;
            ctr         <= '0;
            READ_ENABLE <= 1'b1;
          end else if (ctr == RESP_LAST) begin
            state       <= INIT_WAIT;
            ctr         <= '0;
            READ_ENABLE <= 1'b0;
            INIT_DONE   <= 1'b0;
          end
        end
        WAIT_ACK, WAIT_BAT, WAIT_ID, WAIT_EN_ACK: begin
          if (good_byte && (BYTE_READ == exp_byte)) begin
            ctr <= '0;
            case (state)
              WAIT_ACK: begin
                state       <= WAIT_BAT;
                READ_ENABLE <= 1'b1;
              end
              WAIT_BAT: begin
                state       <= WAIT_ID;
                READ_ENABLE <= 1'b1;
              end
              WAIT_ID: begin
                state       <= SEND_EN;
                READ_ENABLE <= 1'b0;
              end
              default: begin
                state       <= RX_B0;
                READ_ENABLE <= 1'b1;
                INIT_DONE   <= 1'b1;
              end
            endcase
          end else if (BYTE_READY || (ctr == RESP_LAST)) begin
            state       <= INIT_WAIT;
            ctr         <= '0;
            READ_ENABLE <= 1'b0;
            INIT_DONE   <= 1'b0;
          end
        end
        RX_B0: begin
          // Only a status byte with its always-one bit set can start a packet
          if (good_byte && BYTE_READ[3]) begin
            sh_status <= BYTE_READ;
            state     <= RX_B1;
            ctr       <= '0;
          end
        end
        RX_B1, RX_B2: begin
          if (good_byte) begin
            if (state == RX_B1) begin
              sh_dx <= BYTE_READ;
              state <= RX_B2;
            end else begin
              sh_dy       <= BYTE_READ;
              state       <= PUBLISH;
              READ_ENABLE <= 1'b0;
            end
            ctr <= '0;
          end else if (bad_byte || (ctr == PKT_LAST)) begin
            state <= RX_B0;
            ctr   <= '0;
          end
        end
        PUBLISH: begin
          MOUSE_STATUS   <= sh_status;
          MOUSE_DX       <= sh_dx;
          MOUSE_DY       <= sh_dy;
          SEND_INTERRUPT <= 1'b1;
          state          <= RX_B0;
          ctr            <= '0;
          READ_ENABLE    <= 1'b1;
        end
        default: begin
          state       <= INIT_WAIT;
          ctr         <= '0;
          READ_ENABLE <= 1'b0;
          INIT_DONE   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm with shortened timing parameters.
module tb_mouse_master_sm;

  localparam int unsigned T_INIT = 16;
  localparam int unsigned T_RESP = 40;
  localparam int unsigned T_PKT  = 20;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic       INIT_DONE;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;

  int checks = 0;
  int errors = 0;
  int intr_count = 0;

  mouse_master_sm #(
    .T_INIT_WAIT(T_INIT),
    .T_RESP_TIMEOUT(T_RESP),
    .T_PKT_TIMEOUT(T_PKT),
    .CTR_WIDTH(24)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SEND_BYTE(SEND_BYTE),
    .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE),
    .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY(BYTE_READY),
    .INIT_DONE(INIT_DONE),
    .MOUSE_STATUS(MOUSE_STATUS),
    .MOUSE_DX(MOUSE_DX),
    .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT)
  );

  always #5 CLK = ~CLK;

  // Count interrupt pulses as seen at each rising edge
  always @(posedge CLK) if (SEND_INTERRUPT === 1'b1) intr_count++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    BYTE_READY = 1'b0;
    BYTE_SENT = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
    tick(2);
    RESET = 1'b0;
  endtask

  // Edges until SEND_BYTE is seen high; 0 if the bound expires
  task automatic wait_send(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge CLK);
      #1;
      if (SEND_BYTE === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_sent();
    BYTE_SENT = 1'b1;
    tick(1);
    BYTE_SENT = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b, input logic [1:0] err);
    BYTE_READ = b;
    BYTE_ERROR_CODE = err;
    BYTE_READY = 1'b1;
    tick(1);
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick(2);
    checks++;
    if ({SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, INIT_DONE, SEND_INTERRUPT} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctrl: got send=%b tx=%h ren=%b done=%b irq=%b, expected all 0",
               SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, INIT_DONE, SEND_INTERRUPT);
    end
    checks++;
    if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_mouse: got %h %h %h, expected 00 00 00", MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
    end
  endtask

  task automatic test_init();
    int n;
    apply_reset();
    wait_send(n);
    checks++;
    if (n != 17 || BYTE_TO_SEND !== 8'hFF) begin
      errors++;
      $display("FAIL init_rst_cmd: got cycle %0d byte %h, expected cycle 17 byte ff", n, BYTE_TO_SEND);
    end
    tick(1);
    checks++;
    if (SEND_BYTE !== 1'b0) begin
      errors++;
      $display("FAIL send_pulse_width: got %b, expected 0", SEND_BYTE);
    end
    pulse_sent();
    checks++;
    if (READ_ENABLE !== 1'b1) begin
      errors++;
      $display("FAIL init_read_enable_ack: got %b, expected 1", READ_ENABLE);
    end
    feed(8'hFA, 2'b00);
    feed(8'hAA, 2'b00);
    feed(8'h00, 2'b00);
    wait_send(n);
    checks++;
    if (n != 1 || BYTE_TO_SEND !== 8'hF4 || READ_ENABLE !== 1'b0) begin
      errors++;
      $display("FAIL init_en_cmd: got cycle %0d byte %h ren %b, expected cycle 1 byte f4 ren 0",
               n, BYTE_TO_SEND, READ_ENABLE);
    end
    pulse_sent();
    checks++;
    if (INIT_DONE !== 1'b0) begin
      errors++;
      $display("FAIL init_done_early: got %b, expected 0", INIT_DONE);
    end
    feed(8'hFA, 2'b00);
    checks++;
    if (INIT_DONE !== 1'b1 || READ_ENABLE !== 1'b1) begin
      errors++;
      $display("FAIL init_done: got done %b ren %b, expected 1 1", INIT_DONE, READ_ENABLE);
    end
  endtask

  task automatic test_packet();
    int i0;
    i0 = intr_count;
    feed(8'h28, 2'b00);
    feed(8'h05, 2'b00);
    feed(8'hFB, 2'b00);
    checks++;
    if (SEND_INTERRUPT !== 1'b0 || MOUSE_STATUS !== 8'h00) begin
      errors++;
      $display("FAIL pkt_latency_early: got irq %b status %h, expected 0 00", SEND_INTERRUPT, MOUSE_STATUS);
    end
    tick(1);
    checks++;
    if (SEND_INTERRUPT !== 1'b1 || {MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h2805FB) begin
      errors++;
      $display("FAIL pkt_publish: got irq %b %h %h %h, expected 1 28 05 fb",
               SEND_INTERRUPT, MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
    end
    tick(4);
    checks++;
    if (intr_count - i0 != 1) begin
      errors++;
      $display("FAIL pkt_irq_count: got %0d, expected 1", intr_count - i0);
    end
  endtask

  task automatic test_resync();
    int i0;
    i0 = intr_count;
    feed(8'h18, 2'b00);
    feed(8'h77, 2'b01);
    tick(3);
    checks++;
    if (intr_count != i0 || {MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h2805FB || READ_ENABLE !== 1'b1) begin
      errors++;
      $display("FAIL resync_drop: got irqs %0d %h %h %h ren %b, expected 0 28 05 fb 1",
               intr_count - i0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY, READ_ENABLE);
    end
    feed(8'h18, 2'b10);
    feed(8'h00, 2'b00);
    feed(8'h08, 2'b00);
    feed(8'h01, 2'b00);
    feed(8'h02, 2'b00);
    tick(1);
    checks++;
    if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h080102 || intr_count - i0 != 0 || SEND_INTERRUPT !== 1'b1) begin
      errors++;
      $display("FAIL resync_publish: got %h %h %h irq %b, expected 08 01 02 1",
               MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT);
    end
    tick(2);
    checks++;
    if (intr_count - i0 != 1 || INIT_DONE !== 1'b1) begin
      errors++;
      $display("FAIL resync_irq_count: got %0d done %b, expected 1 1", intr_count - i0, INIT_DONE);
    end
  endtask

  task automatic test_pkt_timeout();
    int i0;
    feed(8'h19, 2'b00);
    feed(8'h21, 2'b00);
    tick(15);
    feed(8'h31, 2'b00);
    tick(1);
    checks++;
    if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h192131) begin
      errors++;
      $display("FAIL pkt_slow_ok: got %h %h %h, expected 19 21 31", MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
    end
    tick(1);
    i0 = intr_count;
    feed(8'h09, 2'b00);
    feed(8'h11, 2'b00);
    tick(25);
    feed(8'h0C, 2'b00);
    tick(3);
    checks++;
    if (intr_count != i0 || {MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h192131) begin
      errors++;
      $display("FAIL pkt_timeout_drop: got irqs %0d %h %h %h, expected 0 19 21 31",
               intr_count - i0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
    end
    feed(8'h22, 2'b00);
    feed(8'h44, 2'b00);
    tick(1);
    checks++;
    if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h0C2244) begin
      errors++;
      $display("FAIL pkt_after_timeout: got %h %h %h, expected 0c 22 44", MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
    end
  endtask

  task automatic test_resp_timeout();
    int n;
    apply_reset();
    wait_send(n);
    wait_send(n);
    checks++;
    if (n != 57 || BYTE_TO_SEND !== 8'hFF || INIT_DONE !== 1'b0) begin
      errors++;
      $display("FAIL resp_timeout_resend: got cycle %0d byte %h done %b, expected 57 ff 0",
               n, BYTE_TO_SEND, INIT_DONE);
    end
  endtask

  task automatic test_ignored_inputs();
    int n;
    apply_reset();
    tick(3);
    feed(8'hFE, 2'b00);
    pulse_sent();
    wait_send(n);
    checks++;
    if (n != 12 || READ_ENABLE !== 1'b0) begin
      errors++;
      $display("FAIL ignore_in_init_wait: got cycle %0d ren %b, expected 12 0", n, READ_ENABLE);
    end
  endtask

  task automatic test_bad_init();
    int n;
    apply_reset();
    wait_send(n);
    pulse_sent();
    feed(8'hFE, 2'b00);
    checks++;
    if (INIT_DONE !== 1'b0 || READ_ENABLE !== 1'b0) begin
      errors++;
      $display("FAIL bad_ack_restart: got done %b ren %b, expected 0 0", INIT_DONE, READ_ENABLE);
    end
    wait_send(n);
    checks++;
    if (n != 17 || BYTE_TO_SEND !== 8'hFF) begin
      errors++;
      $display("FAIL bad_ack_resend: got cycle %0d byte %h, expected 17 ff", n, BYTE_TO_SEND);
    end
    pulse_sent();
    feed(8'hFA, 2'b00);
    feed(8'hAA, 2'b00);
    feed(8'h00, 2'b00);
    wait_send(n);
    pulse_sent();
    feed(8'hFA, 2'b00);
    checks++;
    if (INIT_DONE !== 1'b1) begin
      errors++;
      $display("FAIL bad_ack_retry_done: got %b, expected 1", INIT_DONE);
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    feed(8'h08, 2'b00);
    feed(8'h7F, 2'b00);
    feed(8'h80, 2'b00);
    tick(1);
    checks++;
    if ({MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 24'h087F80) begin
      errors++;
      $display("FAIL mid_pre_publish: got %h %h %h, expected 08 7f 80", MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
    end
    feed(8'h0B, 2'b00);
    feed(8'h01, 2'b00);
    RESET = 1'b1;
    #1;
    checks++;
    if ({SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, INIT_DONE, SEND_INTERRUPT,
         MOUSE_STATUS, MOUSE_DX, MOUSE_DY} !== 36'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got tx %h ren %b done %b mouse %h %h %h, expected all 0",
               BYTE_TO_SEND, READ_ENABLE, INIT_DONE, MOUSE_STATUS, MOUSE_DX, MOUSE_DY);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    wait_send(n);
    checks++;
    if (n != 17 || BYTE_TO_SEND !== 8'hFF) begin
      errors++;
      $display("FAIL mid_reset_reinit: got cycle %0d byte %h, expected 17 ff", n, BYTE_TO_SEND);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_packet();
    test_resync();
    test_pkt_timeout();
    test_resp_timeout();
    test_ignored_inputs();
    test_bad_init();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
